// File: rtl/alu_arbiter_if.sv
// Bundle of the requester, response and ALU-side signals around alu_arbiter.
// master = requester/ALU environment, slave = the arbiter itself.
interface alu_arbiter_if #(
  parameter int W   = 4,
  parameter int OPW = 2
);
  logic           req0_valid, req1_valid;
  logic           req0_ready, req1_ready;
  logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
  logic [OPW-1:0] req0_op, req1_op;
  logic           rsp0_valid, rsp1_valid;
  logic           rsp0_ready, rsp1_ready;
  logic [W-1:0]   rsp_ans;
  logic [W-1:0]   alu_a, alu_b;
  logic [OPW-1:0] alu_op;
  logic [W-1:0]   alu_ans;
  logic           busy;

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_op, req1_op,
    output rsp0_ready, rsp1_ready, alu_ans,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_ans,
    input  alu_a, alu_b, alu_op, busy
  );

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_op, req1_op,
    input  rsp0_ready, rsp1_ready, alu_ans,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_ans,
    output alu_a, alu_b, alu_op, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one external combinational ALU between two
// requesters: accept -> one EXEC cycle -> hold registered result until taken.
module alu_arbiter #(
  parameter int W   = 4,
  parameter int OPW = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         stateReg, stateNext;
  logic           lastReg, ownerReg;
  logic [W-1:0]   aReg, bReg, ansReg;
  logic [OPW-1:0] opReg;
  logic           grant0, grant1, rspTaken;

  // A tie goes to whichever requester was not served last.
  always_comb begin
    grant0   = (stateReg == IDLE) && bus.req0_valid && (!bus.req1_valid || lastReg);
    grant1   = (stateReg == IDLE) && bus.req1_valid && (!bus.req0_valid || !lastReg);
    rspTaken = (stateReg == RESP) && (ownerReg ? bus.rsp1_ready : bus.rsp0_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stateReg <= IDLE;
    else        stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (grant0 || grant1) stateNext = EXEC;
      EXEC:    stateNext = RESP;
      RESP:    if (rspTaken) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lastReg  <= 1'b1;
      ownerReg <= 1'b0;
      aReg     <= '0;
      bReg     <= '0;
      opReg    <= '0;
      ansReg   <= '0;
    end else begin
      if (grant0) begin
        aReg     <= bus.req0_a;
        bReg     <= bus.req0_b;
        opReg    <= bus.req0_op;
        ownerReg <= 1'b0;
      end else if (grant1) begin
        aReg     <= bus.req1_a;
        bReg     <= bus.req1_b;
        opReg    <= bus.req1_op;
        ownerReg <= 1'b1;
      end
      if (stateReg == EXEC) ansReg <= bus.alu_ans;
      if (rspTaken) lastReg <= ownerReg;
    end
  end

  always_comb begin
    bus.req0_ready = grant0;
    bus.req1_ready = grant1;
    bus.rsp0_valid = (stateReg == RESP) && !ownerReg;
    bus.rsp1_valid = (stateReg == RESP) && ownerReg;
    bus.rsp_ans    = ansReg;
    bus.alu_a      = aReg;
    bus.alu_b      = bReg;
    bus.alu_op     = opReg;
    bus.busy       = (stateReg != IDLE);
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural 4-bit ALU attached to the
// ALU-side signals; every expected value is hand-computed.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nChecks = 0;
  int   nFails  = 0;

  alu_arbiter_if #(.W(4), .OPW(2)) bus ();

  alu_arbiter #(.W(4), .OPW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [4:0] aluSum;
  always_comb begin
    aluSum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
    case (bus.alu_op)
      2'd0:    bus.alu_ans = bus.alu_a & bus.alu_b;
      2'd1:    bus.alu_ans = bus.alu_a | bus.alu_b;
      2'd2:    bus.alu_ans = bus.alu_a ^ bus.alu_b;
      default: bus.alu_ans = aluSum[3:0];
    endcase
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic setReq(input int n, input logic v, input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] op);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered one time unit after an edge with the DUT in IDLE; leaves it in IDLE.
  task automatic doOp(input int n, input logic [3:0] a, input logic [3:0] b,
                      input logic [1:0] op, input logic [3:0] exp);
    setReq(n, 1'b1, a, b, op);
    #1;
    checkVal("ownReady",   32'(n == 0 ? bus.req0_ready : bus.req1_ready), 32'd1);
    checkVal("otherReady", 32'(n == 0 ? bus.req1_ready : bus.req0_ready), 32'd0);
    step();
    bus.req0_valid = (n == 0) ? 1'b0 : bus.req0_valid;
    bus.req1_valid = (n == 1) ? 1'b0 : bus.req1_valid;
    checkVal("execBusy", 32'(bus.busy), 32'd1);
    checkVal("execAluA", 32'(bus.alu_a), 32'(a));
    checkVal("execAluB", 32'(bus.alu_b), 32'(b));
    checkVal("execAluOp", 32'(bus.alu_op), 32'(op));
    step();
    checkVal("rspOwnValid",   32'(n == 0 ? bus.rsp0_valid : bus.rsp1_valid), 32'd1);
    checkVal("rspOtherValid", 32'(n == 0 ? bus.rsp1_valid : bus.rsp0_valid), 32'd0);
    checkVal("rspAns", 32'(bus.rsp_ans), 32'(exp));
    if (n == 0) bus.rsp0_ready = 1'b1; else bus.rsp1_ready = 1'b1;
    step();
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    checkVal("doneBusy", 32'(bus.busy), 32'd0);
    $display("op req%0d a=%h b=%h op=%0d ans=%h", n, a, b, op, bus.rsp_ans);
  endtask

  initial begin
    setReq(0, 1'b0, 4'h0, 4'h0, 2'd0);
    setReq(1, 1'b0, 4'h0, 4'h0, 2'd0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkVal("rstBusy", 32'(bus.busy), 32'd0);
    checkVal("rstRsp0", 32'(bus.rsp0_valid), 32'd0);
    checkVal("rstRsp1", 32'(bus.rsp1_valid), 32'd0);
    checkVal("rstAns",  32'(bus.rsp_ans), 32'd0);
    checkVal("rstAluA", 32'(bus.alu_a), 32'd0);
    checkVal("rstAluOp", 32'(bus.alu_op), 32'd0);
    rst_n = 1'b1;
    step();

    // First operation and op sweep on requester 1
    doOp(0, 4'hC, 4'hA, 2'd0, 4'h8);
    doOp(1, 4'h9, 4'h8, 2'd0, 4'h8);
    doOp(1, 4'h9, 4'h8, 2'd1, 4'h9);
    doOp(1, 4'h9, 4'h8, 2'd2, 4'h1);
    doOp(1, 4'h9, 4'h8, 2'd3, 4'h1);

    // Continuous contention, responses always taken: strict alternation every 3 cycles
    setReq(0, 1'b1, 4'h3, 4'h4, 2'd3);
    setReq(1, 1'b1, 4'hF, 4'h5, 2'd2);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      checkVal("rrReady0", 32'(bus.req0_ready), 32'(i % 2 == 0));
      checkVal("rrReady1", 32'(bus.req1_ready), 32'(i % 2 == 1));
      step();
      checkVal("rrExecBusy", 32'(bus.busy), 32'd1);
      step();
      checkVal("rrRspValid", 32'(i % 2 == 0 ? bus.rsp0_valid : bus.rsp1_valid), 32'd1);
      checkVal("rrAns", 32'(bus.rsp_ans), (i % 2 == 0) ? 32'h7 : 32'hA);
      $display("op req%0d contention ans=%h", i % 2, bus.rsp_ans);
      step();
    end
    setReq(0, 1'b0, 4'h0, 4'h0, 2'd0);
    setReq(1, 1'b0, 4'h0, 4'h0, 2'd0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    #1;

    // Response back-pressure while requester 1 waits; non-owner ready ignored
    setReq(0, 1'b1, 4'h2, 4'h3, 2'd3);
    #1;
    checkVal("bpReady0", 32'(bus.req0_ready), 32'd1);
    step();
    bus.req0_valid = 1'b0;
    setReq(1, 1'b1, 4'h6, 4'h5, 2'd1);
    bus.rsp1_ready = 1'b1;
    #1;
    checkVal("bpExecReady1", 32'(bus.req1_ready), 32'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      checkVal("bpRsp0", 32'(bus.rsp0_valid), 32'd1);
      checkVal("bpRsp1", 32'(bus.rsp1_valid), 32'd0);
      checkVal("bpAns", 32'(bus.rsp_ans), 32'h5);
      checkVal("bpReady1", 32'(bus.req1_ready), 32'd0);
      step();
    end
    bus.rsp0_ready = 1'b1;
    #1;
    checkVal("bpLastReady1", 32'(bus.req1_ready), 32'd0);
    step();
    bus.rsp0_ready = 1'b0;
    checkVal("bpIdleReady1", 32'(bus.req1_ready), 32'd1);
    step();
    bus.req1_valid = 1'b0;
    checkVal("bpExecAluA", 32'(bus.alu_a), 32'h6);
    step();
    checkVal("bpRsp1Valid", 32'(bus.rsp1_valid), 32'd1);
    checkVal("bpRsp1Ans", 32'(bus.rsp_ans), 32'h7);
    $display("op req1 a=6 b=5 op=1 ans=%h", bus.rsp_ans);
    step();
    bus.rsp1_ready = 1'b0;
    checkVal("bpDoneBusy", 32'(bus.busy), 32'd0);

    // Reset during EXEC abandons the operation and restores the tie-break
    doOp(0, 4'h1, 4'h1, 2'd3, 4'h2);
    setReq(1, 1'b1, 4'hF, 4'hF, 2'd0);
    #1;
    checkVal("rsReady1", 32'(bus.req1_ready), 32'd1);
    step();
    bus.req1_valid = 1'b0;
    bus.rsp1_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    checkVal("rsBusy", 32'(bus.busy), 32'd0);
    checkVal("rsAns",  32'(bus.rsp_ans), 32'd0);
    checkVal("rsAluA", 32'(bus.alu_a), 32'd0);
    checkVal("rsRsp1", 32'(bus.rsp1_valid), 32'd0);
    step();
    checkVal("rsRsp1Later", 32'(bus.rsp1_valid), 32'd0);
    rst_n = 1'b1;
    bus.rsp1_ready = 1'b0;
    step();
    checkVal("rsRsp1After", 32'(bus.rsp1_valid), 32'd0);
    setReq(0, 1'b1, 4'h3, 4'h4, 2'd3);
    setReq(1, 1'b1, 4'hF, 4'h5, 2'd2);
    #1;
    checkVal("rsTie0", 32'(bus.req0_ready), 32'd1);
    checkVal("rsTie1", 32'(bus.req1_ready), 32'd0);
    bus.req1_valid = 1'b0;
    doOp(0, 4'h3, 4'h4, 2'd3, 4'h7);

    // Request withdrawn while busy is never accepted
    doOp(0, 4'h0, 4'h0, 2'd1, 4'h0);
    setReq(1, 1'b1, 4'hC, 4'h3, 2'd1);
    #1;
    checkVal("wdReady1", 32'(bus.req1_ready), 32'd1);
    step();
    bus.req1_valid = 1'b0;
    step();
    setReq(0, 1'b1, 4'h1, 4'h1, 2'd2);
    #1;
    checkVal("wdRspAns", 32'(bus.rsp_ans), 32'hF);
    checkVal("wdReady0Resp", 32'(bus.req0_ready), 32'd0);
    step();
    bus.req0_valid = 1'b0;
    bus.rsp1_ready = 1'b1;
    step();
    bus.rsp1_ready = 1'b0;
    checkVal("wdReady0Idle", 32'(bus.req0_ready), 32'd0);
    step();
    checkVal("wdBusy", 32'(bus.busy), 32'd0);
    checkVal("wdAluA", 32'(bus.alu_a), 32'hC);
    checkVal("wdAluB", 32'(bus.alu_b), 32'h3);
    checkVal("wdAluOp", 32'(bus.alu_op), 32'd1);
    $display("op req1 a=c b=3 op=1 ans=%h (req0 withdrawn)", bus.rsp_ans);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
